// File: rtl/delay_pkg.sv
// Shared constants and types for the effects-engine delay-line interface.
// Slot map, buffer geometry and the responder FSM state encoding.
package delay_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 11;

  localparam logic [9:0] SLOT_TAP0  = 10'h0;
  localparam logic [9:0] SLOT_TAP1  = 10'h1;
  localparam logic [9:0] SLOT_TAP2  = 10'h2;
  localparam logic [9:0] SLOT_TAP3  = 10'h3;
  localparam logic [9:0] SLOT_TAP4  = 10'h4;
  localparam logic [9:0] WRITE_SLOT = 10'h5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

endpackage

// File: rtl/sp_ram_rf.sv
// Single-port block RAM, registered read, read-first on collision.
// No reset on the array or read register so it maps to BRAM.
module sp_ram_rf #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // write port plus read of the pre-write contents
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_line_ram.sv
// Delay-line sample buffer responder: clears on reset, then serves
// one read per clock and one slot-qualified write per frame.
module delay_line_ram #(
  parameter int unsigned ADDR_W     = delay_pkg::ADDR_W,
  parameter int unsigned DATA_W     = delay_pkg::DATA_W,
  parameter logic [9:0]  WRITE_SLOT = delay_pkg::WRITE_SLOT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        counter,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeVoltage,
  input  logic              freeze,
  output logic [DATA_W-1:0] readVoltage,
  output logic              ready
);

  import delay_pkg::*;

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              slot_q;
  logic              ready_q;
  logic              in_slot;
  logic              wr_fire;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign in_slot = (counter == WRITE_SLOT);
  assign wr_fire = (state_q == RUN) && in_slot
                && !slot_q && !freeze;

  // FSM state and sweep pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // sweep advance and hand-over to RUN after the last cell
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // slot edge memory and ready / read-valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      slot_q  <= in_slot;
      ready_q <= (state_q == RUN);
    end
  end

  // sweep owns the RAM port in CLEAR, engine owns it in RUN
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = address;
    ram_wdata = writeVoltage;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_ptr_q;
      ram_wdata = '0;
    end else begin
      ram_we    = wr_fire;
    end
  end

  sp_ram_rf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // ready_q marks that the RAM register holds a RUN-phase read
  assign readVoltage = ready_q ? ram_rdata : '0;
  assign ready       = ready_q;

endmodule

// File: tb/tb_delay_line_ram.sv
// Directed bench for delay_line_ram with a read-result scoreboard.
// Reads push expected data; each clock pops and compares one entry.
module tb_delay_line_ram;

  logic        clk;
  logic        reset;
  logic [9:0]  counter;
  logic [12:0] address;
  logic [10:0] writeVoltage;
  logic        freeze;
  logic [10:0] readVoltage;
  logic        ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t sb [$];

  delay_line_ram dut (
    .clk          (clk),
    .reset        (reset),
    .counter      (counter),
    .address      (address),
    .writeVoltage (writeVoltage),
    .freeze       (freeze),
    .readVoltage  (readVoltage),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, 32'(readVoltage), 32'(e.val));
    end
  endtask

  task automatic rd(input string tag,
                    input logic [12:0] a,
                    input logic [10:0] v);
    exp_t e;
    address = a;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
    tick();
  endtask

  task automatic wr_frame(input logic [12:0] a,
                          input logic [10:0] v);
    counter = 10'd4;
    tick();
    address = a;
    writeVoltage = v;
    counter = 10'd5;
    tick();
    counter = 10'd6;
    tick();
  endtask

  task automatic sweep(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    address = 13'h0ABC;
    writeVoltage = 11'h3FF;
    do begin
      counter = counter + 10'd1;
      tick();
      n++;
      if (!ready && readVoltage !== 11'h0) bad++;
    end while (!ready && n < 9000);
    chk({tag, "_len"}, 32'(n), 32'd8193);
    chk({tag, "_rd0"}, 32'(bad), 32'd0);
    chk({tag, "_first"}, 32'(readVoltage), 32'h0);
    counter = 10'd0;
  endtask

  initial begin
    logic [12:0] wrap_a;
    reset = 1'b1;
    counter = 10'd0;
    address = 13'h0ABC;
    writeVoltage = 11'h0;
    freeze = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rd", 32'(readVoltage), 32'h0);
    tick();
    tick();
    chk("rst_ready2", 32'(ready), 32'd0);
    reset = 1'b0;

    sweep("sweep1");

    wr_frame(13'h0100, 11'h4A5);
    rd("wr_rd", 13'h0100, 11'h4A5);

    counter = 10'd4;
    address = 13'h0200;
    tick();
    counter = 10'd5;
    writeVoltage = 11'h011; tick();
    writeVoltage = 11'h022; tick();
    writeVoltage = 11'h033; tick();
    writeVoltage = 11'h044; tick();
    counter = 10'd6;
    tick();
    rd("dwell", 13'h0200, 11'h011);

    freeze = 1'b1;
    counter = 10'd4;
    address = 13'h0200;
    tick();
    counter = 10'd5;
    writeVoltage = 11'h055; tick();
    writeVoltage = 11'h066; tick();
    writeVoltage = 11'h077; tick();
    writeVoltage = 11'h088; tick();
    counter = 10'd6;
    tick();
    freeze = 1'b0;
    rd("freeze", 13'h0200, 11'h011);

    counter = 10'd4;
    address = 13'h0200;
    tick();
    freeze = 1'b1;
    counter = 10'd5;
    writeVoltage = 11'h099;
    tick();
    freeze = 1'b0;
    tick();
    tick();
    counter = 10'd6;
    tick();
    rd("frz_edge", 13'h0200, 11'h011);

    freeze = 1'b1;
    counter = 10'd4;
    tick();
    freeze = 1'b0;
    wr_frame(13'h0200, 11'h0AA);
    rd("frz_lift", 13'h0200, 11'h0AA);

    wr_frame(13'h1FFF, 11'h123);
    counter = 10'd4;
    tick();
    counter = 10'd5;
    writeVoltage = 11'h7FF;
    rd("rf_old", 13'h1FFF, 11'h123);
    counter = 10'd6;
    rd("rf_new", 13'h1FFF, 11'h7FF);

    wr_frame(13'h0000, 11'h200);
    wrap_a = 13'h0000 - 13'h0200;
    wr_frame(wrap_a, 11'h3AA);
    rd("wrap_tap", wrap_a, 11'h3AA);
    rd("wrap_base", 13'h0000, 11'h200);
    wr_frame(13'h0005, 11'h400);
    rd("neg_zero", 13'h0005, 11'h400);
    rd("rd_4A5", 13'h0100, 11'h4A5);

    reset = 1'b1;
    #1;
    chk("rrun_ready", 32'(ready), 32'd0);
    chk("rrun_rd", 32'(readVoltage), 32'h0);
    tick();
    reset = 1'b0;
    repeat (2048) tick();
    chk("mid_ready", 32'(ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rclr_ready", 32'(ready), 32'd0);
    tick();
    reset = 1'b0;

    sweep("sweep2");

    rd("clr_100", 13'h0100, 11'h0);
    rd("clr_200", 13'h0200, 11'h0);
    rd("clr_1FFF", 13'h1FFF, 11'h0);
    rd("clr_1E00", wrap_a, 11'h0);
    rd("clr_0000", 13'h0000, 11'h0);
    rd("clr_0005", 13'h0005, 11'h0);
    chk("ready_end", 32'(ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
